// File: rtl/nec_ir_decoder.sv
// NEC infrared frame decoder: synchronizes the IR receiver output, measures
// mark/space widths in microseconds and assembles 32-bit frames.
module nec_ir_decoder #(
  parameter int CLK_HZ        = 50000000,
  parameter bit CHECK_CMD_INV = 1'b1,
  // microseconds per width tick; lets clocks slower than 1 MHz still measure
  parameter int TICK_US       = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ir,
  input  logic        rd,
  output logic [31:0] data,
  output logic        data_ready,
  output logic        repeat_pulse,
  output logic        frame_err
);

  localparam longint DIV_L = (longint'(CLK_HZ) * longint'(TICK_US)) / 64'sd1000000;
  localparam int     DIV   = (DIV_L < 1) ? 1 : int'(DIV_L);
  localparam int     PW    = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [14:0] W_LEAD_LO = 15'd8000;
  localparam logic [14:0] W_LEAD_HI = 15'd10000;
  localparam logic [14:0] W_HDR_LO  = 15'd4000;
  localparam logic [14:0] W_HDR_HI  = 15'd5000;
  localparam logic [14:0] W_RPT_LO  = 15'd1800;
  localparam logic [14:0] W_RPT_HI  = 15'd2700;
  localparam logic [14:0] W_SHORT_LO = 15'd400;
  localparam logic [14:0] W_SHORT_HI = 15'd750;
  localparam logic [14:0] W_ONE_LO  = 15'd1400;
  localparam logic [14:0] W_ONE_HI  = 15'd1950;
  localparam logic [14:0] W_TMO     = 15'd12000;

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, RPT_MARK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [14:0]   width_q, width_d;
  logic [31:0]   shift_q, shift_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [31:0]   data_q, data_d;
  logic          data_ready_q, data_ready_d;
  logic          have_frame_q, have_frame_d;
  logic          repeat_q, repeat_d;
  logic          err_q, err_d;

  logic          rise, fall, edge_any, tick, commit, cmd_ok;
  logic [15:0]   width_sum;
  logic [14:0]   width_inc, meas;

  function automatic logic in_rng(input logic [14:0] w, input logic [14:0] lo,
                                  input logic [14:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  assign rise     = ~prev_q & sync2_q;
  assign fall     = prev_q & ~sync2_q;
  assign edge_any = rise | fall;
  assign tick     = (presc_q == PW'(DIV - 1));

  assign width_sum = {1'b0, width_q} + 16'(TICK_US);
  assign width_inc = width_sum[15] ? 15'h7fff : width_sum[14:0];
  // width of the phase ending now, including the tick completing this cycle
  assign meas      = tick ? width_inc : width_q;
  assign cmd_ok    = !CHECK_CMD_INV || (shift_q[31:24] == ~shift_q[23:16]);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    have_frame_d = have_frame_q;
    repeat_d     = 1'b0;
    err_d        = 1'b0;
    commit       = 1'b0;
    presc_d      = presc_q;
    width_d      = width_q;

    if (edge_any) begin
      presc_d = '0;
      width_d = '0;
    end else if (tick) begin
      presc_d = '0;
      width_d = width_inc;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (state_q == IDLE) begin
      if (fall) state_d = LEAD_MARK;
    end else if (!edge_any) begin
      if (meas >= W_TMO) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end else begin
      // marks and spaces alternate, so the edge seen here always ends the
      // phase the current state is timing
      state_d = IDLE;
      err_d   = 1'b1;
      case (state_q)
        LEAD_MARK: if (in_rng(meas, W_LEAD_LO, W_LEAD_HI)) begin
          state_d = LEAD_SPACE;
          err_d   = 1'b0;
        end
        LEAD_SPACE: if (in_rng(meas, W_HDR_LO, W_HDR_HI)) begin
          state_d   = BIT_MARK;
          bit_cnt_d = '0;
          err_d     = 1'b0;
        end else if (in_rng(meas, W_RPT_LO, W_RPT_HI)) begin
          state_d = RPT_MARK;
          err_d   = 1'b0;
        end
        BIT_MARK: if (in_rng(meas, W_SHORT_LO, W_SHORT_HI)) begin
          if (bit_cnt_q == 6'd32) begin
            if (cmd_ok) begin
              commit       = 1'b1;
              data_d       = shift_q;
              have_frame_d = 1'b1;
              err_d        = 1'b0;
            end
          end else begin
            state_d = BIT_SPACE;
            err_d   = 1'b0;
          end
        end
        BIT_SPACE: if (in_rng(meas, W_SHORT_LO, W_SHORT_HI) ||
                       in_rng(meas, W_ONE_LO, W_ONE_HI)) begin
          shift_d   = {in_rng(meas, W_ONE_LO, W_ONE_HI), shift_q[31:1]};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = BIT_MARK;
          err_d     = 1'b0;
        end
        RPT_MARK: if (in_rng(meas, W_SHORT_LO, W_SHORT_HI)) begin
          repeat_d = have_frame_q;
          err_d    = 1'b0;
        end
        default: ;
      endcase
    end

    // a commit outranks a simultaneous read
    data_ready_d = commit ? 1'b1 : (rd ? 1'b0 : data_ready_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= IDLE;
      presc_q      <= '0;
      width_q      <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      data_ready_q <= 1'b0;
      have_frame_q <= 1'b0;
      repeat_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync1_q      <= ir;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      state_q      <= state_d;
      presc_q      <= presc_d;
      width_q      <= width_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      data_q       <= data_d;
      data_ready_q <= data_ready_d;
      have_frame_q <= have_frame_d;
      repeat_q     <= repeat_d;
      err_q        <= err_d;
    end
  end

  assign data         = data_q;
  assign data_ready   = data_ready_q;
  assign repeat_pulse = repeat_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Directed bench for nec_ir_decoder; a 100 kHz clock with 10 us ticks keeps
// whole NEC frames short in cycles.
module tb_nec_ir_decoder;
  localparam int TICK = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ir = 1'b1;
  logic        rd = 1'b0;
  logic [31:0] data, data0;
  logic        data_ready, data_ready0;
  logic        repeat_pulse, repeat_pulse0;
  logic        frame_err, frame_err0;

  int n_chk = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int rpt_cnt = 0;

  nec_ir_decoder #(.CLK_HZ(100000), .CHECK_CMD_INV(1'b1), .TICK_US(TICK)) dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .rd(rd), .data(data),
    .data_ready(data_ready), .repeat_pulse(repeat_pulse), .frame_err(frame_err));

  nec_ir_decoder #(.CLK_HZ(100000), .CHECK_CMD_INV(1'b0), .TICK_US(TICK)) dut0 (
    .clk(clk), .reset_n(reset_n), .ir(ir), .rd(1'b0), .data(data0),
    .data_ready(data_ready0), .repeat_pulse(repeat_pulse0), .frame_err(frame_err0));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err)    err_cnt <= err_cnt + 1;
    if (repeat_pulse) rpt_cnt <= rpt_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark(input int us);
    ir = 1'b0;
    wait_cyc(us / TICK);
  endtask

  task automatic space(input int us);
    ir = 1'b1;
    wait_cyc(us / TICK);
  endtask

  task automatic send_bit(input logic b);
    mark(560);
    space(b ? 1690 : 560);
  endtask

  task automatic send_head(input int lead_us, input logic [31:0] w, input int nbits);
    mark(lead_us);
    space(4500);
    for (int i = 0; i < nbits; i++) send_bit(w[i]);
  endtask

  // full frame; returns with ir just released after the stop mark
  task automatic send_frame(input int lead_us, input logic [31:0] w);
    send_head(lead_us, w, 32);
    mark(560);
    ir = 1'b1;
  endtask

  task automatic send_repeat();
    mark(9000);
    space(2250);
    mark(560);
    ir = 1'b1;
  endtask

  initial begin
    wait_cyc(3);
    chk("rst_data", data, 32'h0);
    chk("rst_ready", {31'h0, data_ready}, 32'h0);
    chk("rst_rpt", {31'h0, repeat_pulse}, 32'h0);
    chk("rst_err", {31'h0, frame_err}, 32'h0);
    reset_n = 1'b1;
    space(2000);

    // repeat code with no stored frame
    send_repeat();
    space(2000);
    chk("rpt_no_frame", rpt_cnt, 0);

    // first frame: ready three clocks after the stop mark ends
    send_frame(9000, 32'hBA45FF00);
    wait_cyc(2);
    chk("ready_early", {31'h0, data_ready}, 32'h0);
    wait_cyc(1);
    chk("f1_ready", {31'h0, data_ready}, 32'h1);
    chk("f1_data", data, 32'hBA45FF00);
    chk("f1_no_err", err_cnt, 0);
    rd = 1'b1; wait_cyc(1); rd = 1'b0;
    chk("rd_clear", {31'h0, data_ready}, 32'h0);
    chk("rd_hold", data, 32'hBA45FF00);
    space(2000);

    send_repeat();
    space(2000);
    chk("rpt_cnt", rpt_cnt, 1);
    chk("rpt_data", data, 32'hBA45FF00);
    chk("rpt_no_err", err_cnt, 0);

    // broken inverse command byte
    send_frame(9000, 32'hBB45FF00);
    space(2000);
    chk("inv_err", err_cnt, 1);
    chk("inv_data", data, 32'hBA45FF00);
    chk("inv_ready", {31'h0, data_ready}, 32'h0);
    chk("noinv_data", data0, 32'hBB45FF00);

    // leader just too short, then exactly minimum
    mark(7990);
    space(2000);
    chk("lead_7990", err_cnt, 2);
    send_frame(8000, 32'hDD22EF10);
    space(2000);
    chk("lead_8000_data", data, 32'hDD22EF10);
    chk("lead_8000_err", err_cnt, 2);

    // bit space in the gap between zero and one windows
    send_head(9000, 32'h3, 2);
    mark(560);
    space(1000);
    mark(560);
    space(2000);
    chk("space_1000", err_cnt, 3);

    // stall after 16 marks: timeout 12 ms after the last rising edge
    send_head(9000, 32'hF807FF00, 15);
    mark(560);
    ir = 1'b1;
    wait_cyc(1195);
    chk("stall_early", err_cnt, 3);
    wait_cyc(20);
    chk("stall_err", err_cnt, 4);
    send_frame(9000, 32'hF807FF00);
    space(2000);
    chk("after_stall", data, 32'hF807FF00);
    chk("after_stall_rdy", {31'h0, data_ready}, 32'h1);

    // reset mid-frame
    send_head(9000, 32'hBA45FF00, 20);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_data", data, 32'h0);
    chk("mid_rst_ready", {31'h0, data_ready}, 32'h0);
    chk("mid_rst_err", {31'h0, frame_err}, 32'h0);
    wait_cyc(1);
    reset_n = 1'b1;
    space(2000);
    chk("mid_rst_errcnt", err_cnt, 4);

    // rd on the very cycle the commit lands
    send_frame(9000, 32'hBA45FF00);
    wait_cyc(1);
    @(posedge clk); #1;
    rd = 1'b1;
    wait_cyc(1);
    rd = 1'b0;
    chk("rd_commit_ready", {31'h0, data_ready}, 32'h1);
    chk("rd_commit_data", data, 32'hBA45FF00);
    wait_cyc(5);
    chk("final_err", err_cnt, 4);
    chk("final_rpt", rpt_cnt, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
